// File: rtl/bp_be_fp_wb_arb_if.sv
// FP writeback bus bundle: pipe and long-latency result inputs, register file
// write port, scoreboard pending vector and issue stall request.
interface bp_be_fp_wb_arb_if #(
    parameter int dword_width_p    = 64,
    parameter int reg_addr_width_p = 5
);
    logic                               pipe_v_i;
    logic [reg_addr_width_p-1:0]        pipe_addr_i;
    logic [dword_width_p-1:0]           pipe_data_i;
    logic                               long_v_i;
    logic [reg_addr_width_p-1:0]        long_addr_i;
    logic [dword_width_p-1:0]           long_data_i;
    logic                               long_ready_o;
    logic                               rd_w_v_o;
    logic [reg_addr_width_p-1:0]        rd_addr_o;
    logic [dword_width_p-1:0]           rd_data_o;
    logic [2**reg_addr_width_p-1:0]     pending_o;
    logic                               stall_o;

    modport master (
        output pipe_v_i, pipe_addr_i, pipe_data_i,
        output long_v_i, long_addr_i, long_data_i,
        input  long_ready_o, rd_w_v_o, rd_addr_o, rd_data_o, pending_o, stall_o
    );

    modport slave (
        input  pipe_v_i, pipe_addr_i, pipe_data_i,
        input  long_v_i, long_addr_i, long_data_i,
        output long_ready_o, rd_w_v_o, rd_addr_o, rd_data_o, pending_o, stall_o
    );
endinterface

// File: rtl/bp_be_fp_wb_arb.sv
// FP writeback arbiter: FMA pipe always wins the rd port, long results queue in a
// small FIFO, are killed on WAW against newer pipe writes, and stall issue if starved.
module bp_be_fp_wb_arb #(
    parameter int dword_width_p    = 64,
    parameter int reg_addr_width_p = 5,
    parameter int fifo_els_p       = 2,
    parameter int starve_limit_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    bp_be_fp_wb_arb_if.slave   wb
);
    localparam int ptr_w_lp    = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp    = $clog2(fifo_els_p + 1);
    localparam int starve_w_lp = $clog2(starve_limit_p + 1);
    localparam logic [cnt_w_lp-1:0]    full_cnt_lp   = cnt_w_lp'(fifo_els_p);
    localparam logic [ptr_w_lp-1:0]    last_ptr_lp   = ptr_w_lp'(fifo_els_p - 1);
    localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);

    logic [reg_addr_width_p-1:0] addr_mem [fifo_els_p];
    logic [dword_width_p-1:0]    data_mem [fifo_els_p];

    logic [ptr_w_lp-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [cnt_w_lp-1:0]         count_q, count_d;
    logic [fifo_els_p-1:0]       kill_q, kill_d;
    logic [starve_w_lp-1:0]      starve_q, starve_d;
    logic                        stall_q, stall_d;
    logic                        rd_w_v_q, rd_w_v_d;
    logic [reg_addr_width_p-1:0] rd_addr_q, rd_addr_d;
    logic [dword_width_p-1:0]    rd_data_q, rd_data_d;

    logic                        empty, pop, bypass, long_ready, push, head_killed;
    logic [fifo_els_p-1:0]       valid;
    logic [2**reg_addr_width_p-1:0] pending;

    // Slot i is live when its distance from the head is below the occupancy.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        valid   = '0;
        pending = '0;
        for (int i = 0; i < fifo_els_p; i++) begin
            if (i >= int'(rd_ptr_q))
                valid[i] = (i - int'(rd_ptr_q)) < int'(count_q);
            else
                valid[i] = (i + fifo_els_p - int'(rd_ptr_q)) < int'(count_q);
            if (valid[i] && !kill_q[i])
                pending[addr_mem[i]] = 1'b1;
        end
    end

    assign empty       = (count_q == '0);
    assign pop         = !wb.pipe_v_i && !empty;
    assign bypass      = !wb.pipe_v_i && empty && wb.long_v_i;
    assign long_ready  = (count_q != full_cnt_lp) || bypass;
    assign push        = wb.long_v_i && long_ready && !bypass;
    assign head_killed = kill_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        kill_d   = kill_q;

        if (pop)
            rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + ptr_w_lp'(1);
        if (push)
            wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_w_lp'(1);
        if (push && !pop)
            count_d = count_q + cnt_w_lp'(1);
        else if (pop && !push)
            count_d = count_q - cnt_w_lp'(1);

        // A newer pipe write to the same register makes a buffered result stale.
        if (wb.pipe_v_i) begin
            for (int i = 0; i < fifo_els_p; i++)
                if (valid[i] && addr_mem[i] == wb.pipe_addr_i)
                    kill_d[i] = 1'b1;
        end
        if (push)
            kill_d[wr_ptr_q] = wb.pipe_v_i && (wb.long_addr_i == wb.pipe_addr_i);

        rd_w_v_d = wb.pipe_v_i || (pop && !head_killed) || bypass;
        if (wb.pipe_v_i) begin
            rd_addr_d = wb.pipe_addr_i;
            rd_data_d = wb.pipe_data_i;
        end else if (!empty) begin
            rd_addr_d = addr_mem[rd_ptr_q];
            rd_data_d = data_mem[rd_ptr_q];
        end else begin
            rd_addr_d = wb.long_addr_i;
            rd_data_d = wb.long_data_i;
        end

        if (empty || pop)
            starve_d = '0;
        else if (wb.pipe_v_i && starve_q != starve_max_lp)
            starve_d = starve_q + starve_w_lp'(1);
        else
            starve_d = starve_q;
        stall_d = (starve_d == starve_max_lp) && (count_d != '0);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset_i) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            kill_q    <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            rd_w_v_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            kill_q    <= kill_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            rd_w_v_q  <= rd_w_v_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // NOTE: payload storage has no reset; occupancy and kill bits alone decide what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= wb.long_addr_i;
            data_mem[wr_ptr_q] <= wb.long_data_i;
        end
    end

    assign wb.long_ready_o = long_ready;
    assign wb.rd_w_v_o     = rd_w_v_q;
    assign wb.rd_addr_o    = rd_addr_q;
    assign wb.rd_data_o    = rd_data_q;
    assign wb.pending_o    = pending;
    assign wb.stall_o      = stall_q;

    a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i)
        !(push && count_q == full_cnt_lp));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        !(pop && empty));
    a_pipe_kept: assert property (@(posedge clk_i) disable iff (reset_i)
        wb.pipe_v_i |-> rd_w_v_d);
endmodule

// File: tb/tb_bp_be_fp_wb_arb.sv
// Self-checking bench for bp_be_fp_wb_arb: a scoreboard of expected register
// writes plus per-scenario cycle-exact checks of ready, pending and stall.
module tb_bp_be_fp_wb_arb;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int PW = 2**AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bp_be_fp_wb_arb_if #(.dword_width_p(DW), .reg_addr_width_p(AW)) wb();

    bp_be_fp_wb_arb #(
        .dword_width_p(DW), .reg_addr_width_p(AW),
        .fifo_els_p(2), .starve_limit_p(4)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .wb(wb)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int  vectors = 0;
    int  miscompares = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    // Every register write must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (wb.rd_w_v_o === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_spurious: got write r%0d=%h, expected no write", wb.rd_addr_o, wb.rd_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (wb.rd_addr_o !== mon_e.addr || wb.rd_data_o !== mon_e.data) begin
                    miscompares++;
                    $display("FAIL sb_write: got r%0d=%h, expected r%0d=%h", wb.rd_addr_o, wb.rd_data_o, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pipe(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb.pipe_v_i    = v;
        wb.pipe_addr_i = a;
        wb.pipe_data_i = d;
        if (v) exp_q.push_back({a, d});
    endtask

    task automatic drive_long(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb.long_v_i    = v;
        wb.long_addr_i = a;
        wb.long_data_i = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_pipe(1'b0, '0, '0);
        drive_long(1'b0, '0, '0);
        step();
        step();
        vectors++; if (wb.rd_w_v_o !== 1'b0) begin miscompares++; $display("FAIL reset_rd_w_v: got %b want 0", wb.rd_w_v_o); end
        vectors++; if (wb.rd_addr_o !== '0) begin miscompares++; $display("FAIL reset_rd_addr: got %0d want 0", wb.rd_addr_o); end
        vectors++; if (wb.rd_data_o !== '0) begin miscompares++; $display("FAIL reset_rd_data: got %h want 0", wb.rd_data_o); end
        vectors++; if (wb.stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", wb.stall_o); end
        vectors++; if (wb.pending_o !== '0) begin miscompares++; $display("FAIL reset_pending: got %h want 0", wb.pending_o); end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++; if (wb.rd_w_v_o !== 1'b0) begin miscompares++; $display("FAIL idle_rd_w_v: cycle %0d got %b want 0", i, wb.rd_w_v_o); end
            vectors++; if (wb.long_ready_o !== 1'b1) begin miscompares++; $display("FAIL idle_ready: cycle %0d got %b want 1", i, wb.long_ready_o); end
            vectors++; if (wb.pending_o !== '0) begin miscompares++; $display("FAIL idle_pending: cycle %0d got %h want 0", i, wb.pending_o); end
            vectors++; if (wb.stall_o !== 1'b0) begin miscompares++; $display("FAIL idle_stall: cycle %0d got %b want 0", i, wb.stall_o); end
        end
    endtask

    task automatic test_pipe_and_long();
        drive_pipe(1'b1, 5'd3, 64'hA5);
        drive_long(1'b1, 5'd7, 64'h11);
        #1;
        vectors++; if (wb.long_ready_o !== 1'b1) begin miscompares++; $display("FAIL pl_ready: got %b want 1", wb.long_ready_o); end
        step();
        drive_pipe(1'b0, '0, '0);
        drive_long(1'b0, '0, '0);
        exp_q.push_back({5'd7, 64'h11});
        vectors++; if (wb.rd_w_v_o !== 1'b1 || wb.rd_addr_o !== 5'd3 || wb.rd_data_o !== 64'hA5) begin
            miscompares++; $display("FAIL pl_pipe_write: got v=%b r%0d=%h want v=1 r3=a5", wb.rd_w_v_o, wb.rd_addr_o, wb.rd_data_o); end
        vectors++; if (wb.pending_o !== PW'(1) << 7) begin miscompares++; $display("FAIL pl_pending7: got %h want %h", wb.pending_o, PW'(1) << 7); end
        step();
        vectors++; if (wb.rd_w_v_o !== 1'b1 || wb.rd_addr_o !== 5'd7 || wb.rd_data_o !== 64'h11) begin
            miscompares++; $display("FAIL pl_long_write: got v=%b r%0d=%h want v=1 r7=11", wb.rd_w_v_o, wb.rd_addr_o, wb.rd_data_o); end
        vectors++; if (wb.pending_o !== '0) begin miscompares++; $display("FAIL pl_pending_clear: got %h want 0", wb.pending_o); end
    endtask

    task automatic test_bypass();
        drive_long(1'b1, 5'd9, 64'h22);
        exp_q.push_back({5'd9, 64'h22});
        #1;
        vectors++; if (wb.long_ready_o !== 1'b1) begin miscompares++; $display("FAIL byp_ready: got %b want 1", wb.long_ready_o); end
        vectors++; if (wb.pending_o !== '0) begin miscompares++; $display("FAIL byp_pending_in: got %h want 0", wb.pending_o); end
        step();
        drive_long(1'b0, '0, '0);
        vectors++; if (wb.rd_w_v_o !== 1'b1 || wb.rd_addr_o !== 5'd9 || wb.rd_data_o !== 64'h22) begin
            miscompares++; $display("FAIL byp_write: got v=%b r%0d=%h want v=1 r9=22", wb.rd_w_v_o, wb.rd_addr_o, wb.rd_data_o); end
        vectors++; if (wb.pending_o !== '0) begin miscompares++; $display("FAIL byp_pending_out: got %h want 0", wb.pending_o); end
        step();
        vectors++; if (wb.rd_w_v_o !== 1'b0) begin miscompares++; $display("FAIL byp_no_repeat: got %b want 0", wb.rd_w_v_o); end
    endtask

    task automatic test_starve_and_drain();
        drive_pipe(1'b1, 5'd20, 64'h100);
        drive_long(1'b1, 5'd10, 64'hB0);
        #1;
        vectors++; if (wb.long_ready_o !== 1'b1) begin miscompares++; $display("FAIL st_ready0: got %b want 1", wb.long_ready_o); end
        step();
        drive_pipe(1'b1, 5'd21, 64'h101);
        drive_long(1'b1, 5'd11, 64'hB1);
        #1;
        vectors++; if (wb.long_ready_o !== 1'b1) begin miscompares++; $display("FAIL st_ready1: got %b want 1", wb.long_ready_o); end
        step();
        // Three more pipe cycles with a full FIFO: third long result must be refused.
        for (int i = 0; i < 3; i++) begin
            drive_pipe(1'b1, AW'(22 + i), 64'(32'h102 + i));
            drive_long(1'b1, 5'd12, 64'hB2);
            #1;
            vectors++; if (wb.long_ready_o !== 1'b0) begin miscompares++; $display("FAIL st_full_ready: cycle %0d got %b want 0", i, wb.long_ready_o); end
            step();
            vectors++; if (wb.stall_o !== (i == 2)) begin miscompares++; $display("FAIL st_stall: cycle %0d got %b want %b", i, wb.stall_o, i == 2); end
        end
        vectors++; if (wb.pending_o !== ((PW'(1) << 10) | (PW'(1) << 11))) begin
            miscompares++; $display("FAIL st_pending: got %h want %h", wb.pending_o, (PW'(1) << 10) | (PW'(1) << 11)); end
        drive_pipe(1'b0, '0, '0);
        drive_long(1'b0, '0, '0);
        exp_q.push_back({5'd10, 64'hB0});
        step();
        vectors++; if (wb.rd_w_v_o !== 1'b1 || wb.rd_addr_o !== 5'd10 || wb.rd_data_o !== 64'hB0) begin
            miscompares++; $display("FAIL st_drain0: got v=%b r%0d=%h want v=1 r10=b0", wb.rd_w_v_o, wb.rd_addr_o, wb.rd_data_o); end
        vectors++; if (wb.stall_o !== 1'b0) begin miscompares++; $display("FAIL st_stall_drop: got %b want 0", wb.stall_o); end
        exp_q.push_back({5'd11, 64'hB1});
        step();
        vectors++; if (wb.rd_w_v_o !== 1'b1 || wb.rd_addr_o !== 5'd11 || wb.rd_data_o !== 64'hB1) begin
            miscompares++; $display("FAIL st_drain1: got v=%b r%0d=%h want v=1 r11=b1", wb.rd_w_v_o, wb.rd_addr_o, wb.rd_data_o); end
        vectors++; if (wb.pending_o !== '0) begin miscompares++; $display("FAIL st_pending_empty: got %h want 0", wb.pending_o); end
        step();
        vectors++; if (wb.rd_w_v_o !== 1'b0 || wb.long_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL st_idle: got v=%b ready=%b want v=0 ready=1", wb.rd_w_v_o, wb.long_ready_o); end
    endtask

    task automatic test_waw_kill();
        drive_pipe(1'b1, 5'd6, 64'h66);
        drive_long(1'b1, 5'd5, 64'h55);
        step();
        vectors++; if (wb.pending_o !== PW'(1) << 5) begin miscompares++; $display("FAIL waw_pending5: got %h want %h", wb.pending_o, PW'(1) << 5); end
        drive_pipe(1'b1, 5'd5, 64'h5F);
        drive_long(1'b0, '0, '0);
        step();
        vectors++; if (wb.rd_w_v_o !== 1'b1 || wb.rd_addr_o !== 5'd5 || wb.rd_data_o !== 64'h5F) begin
            miscompares++; $display("FAIL waw_pipe_write: got v=%b r%0d=%h want v=1 r5=5f", wb.rd_w_v_o, wb.rd_addr_o, wb.rd_data_o); end
        vectors++; if (wb.pending_o !== '0) begin miscompares++; $display("FAIL waw_pending_kill: got %h want 0", wb.pending_o); end
        drive_pipe(1'b0, '0, '0);
        step();
        vectors++; if (wb.rd_w_v_o !== 1'b0) begin miscompares++; $display("FAIL waw_killed_pop: got %b want 0", wb.rd_w_v_o); end
        // FIFO must now be empty, so a fresh long result takes the bypass.
        drive_long(1'b1, 5'd9, 64'h99);
        exp_q.push_back({5'd9, 64'h99});
        step();
        drive_long(1'b0, '0, '0);
        vectors++; if (wb.rd_w_v_o !== 1'b1 || wb.rd_addr_o !== 5'd9 || wb.rd_data_o !== 64'h99) begin
            miscompares++; $display("FAIL waw_after_bypass: got v=%b r%0d=%h want v=1 r9=99", wb.rd_w_v_o, wb.rd_addr_o, wb.rd_data_o); end
        drive_pipe(1'b1, 5'd8, 64'h88);
        drive_long(1'b1, 5'd8, 64'h77);
        step();
        drive_pipe(1'b0, '0, '0);
        drive_long(1'b0, '0, '0);
        vectors++; if (wb.pending_o !== '0) begin miscompares++; $display("FAIL waw_push_killed_pending: got %h want 0", wb.pending_o); end
        step();
        vectors++; if (wb.rd_w_v_o !== 1'b0) begin miscompares++; $display("FAIL waw_push_killed_pop: got %b want 0", wb.rd_w_v_o); end
    endtask

    task automatic test_reset_mid();
        drive_pipe(1'b1, 5'd25, 64'h250);
        drive_long(1'b1, 5'd13, 64'hC0);
        step();
        drive_pipe(1'b1, 5'd26, 64'h260);
        drive_long(1'b1, 5'd14, 64'hC1);
        step();
        drive_long(1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            drive_pipe(1'b1, AW'(27 + i), 64'(32'h270 + i));
            step();
        end
        vectors++; if (wb.stall_o !== 1'b1) begin miscompares++; $display("FAIL rm_stall_pre: got %b want 1", wb.stall_o); end
        reset = 1'b1;
        drive_pipe(1'b0, '0, '0);
        step();
        vectors++; if (wb.rd_w_v_o !== 1'b0 || wb.stall_o !== 1'b0) begin
            miscompares++; $display("FAIL rm_outputs: got v=%b stall=%b want v=0 stall=0", wb.rd_w_v_o, wb.stall_o); end
        vectors++; if (wb.pending_o !== '0 || wb.long_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL rm_fifo_empty: got pending=%h ready=%b want pending=0 ready=1", wb.pending_o, wb.long_ready_o); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++; if (wb.rd_w_v_o !== 1'b0) begin miscompares++; $display("FAIL rm_no_write: cycle %0d got %b want 0", i, wb.rd_w_v_o); end
        end
    endtask

    initial begin
        test_reset();
        test_pipe_and_long();
        test_bypass();
        test_starve_and_drain();
        test_waw_kill();
        test_reset_mid();
        step();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d unwritten results, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
